// File: rtl/inst_queue.sv
// Instruction queue: issues sequential fetches to the I-cache (one outstanding)
// and buffers returned {inst, pc} pairs in a circular FIFO for the decoder.
module inst_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic        IC_S,
  output logic [31:0] IC_pc,
  input  logic        IC_Success,
  input  logic [31:0] IC_Inst,
  output logic        IQ_S,
  output logic [31:0] IQ_Inst,
  output logic [31:0] IQ_pc,
  input  logic        IQ_Success,
  input  logic        ROB_Clear,
  input  logic [31:0] ROB_NewPc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [31:0]   fpc, fpc_nx;
  logic          ic_s_nx;
  logic [31:0]   ic_pc_nx;
  logic          push, pop;

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  assign IQ_S    = (count != '0) && !ROB_Clear;
  assign IQ_Inst = IQ_S ? mem_inst[head] : '0;
  assign IQ_pc   = IQ_S ? mem_pc[head]   : '0;

  always_comb begin
    state_nx = state;
    ic_s_nx  = IC_S;
    ic_pc_nx = IC_pc;
    fpc_nx   = fpc;
    push     = 1'b0;
    pop      = IQ_S && IQ_Success;
    case (state)
      IDLE: begin
        if (!ROB_Clear && (count < FULL_CNT)) begin
          state_nx = WAIT;
          ic_s_nx  = 1'b1;
          ic_pc_nx = fpc;
        end
      end
      WAIT: begin
        // A response landing in the clear cycle is dropped; nothing left to drain.
        if (ROB_Clear) begin
          ic_s_nx  = 1'b0;
          state_nx = IC_Success ? IDLE : DRAIN;
        end else if (IC_Success) begin
          push     = 1'b1;
          fpc_nx   = fpc + 32'd4;
          ic_s_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (IC_Success) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (ROB_Clear) fpc_nx = ROB_NewPc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      IC_S  <= 1'b0;
      IC_pc <= '0;
      fpc   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      state <= state_nx;
      IC_S  <= ic_s_nx;
      IC_pc <= ic_pc_nx;
      fpc   <= fpc_nx;
      if (ROB_Clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && push) begin
      mem_inst[tail] <= IC_Inst;
      mem_pc[tail]   <= IC_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Randomized bench for inst_queue: a queue-based reference model plus a
// behavioural I-cache with random latency that keeps answering stale requests.
module tb_inst_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NCYC  = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        IC_S;
  logic [31:0] IC_pc;
  logic        IC_Success = 1'b0;
  logic [31:0] IC_Inst = '0;
  logic        IQ_S;
  logic [31:0] IQ_Inst;
  logic [31:0] IQ_pc;
  logic        IQ_Success = 1'b0;
  logic        ROB_Clear = 1'b0;
  logic [31:0] ROB_NewPc = '0;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .IC_S(IC_S), .IC_pc(IC_pc), .IC_Success(IC_Success), .IC_Inst(IC_Inst),
    .IQ_S(IQ_S), .IQ_Inst(IQ_Inst), .IQ_pc(IQ_pc), .IQ_Success(IQ_Success),
    .ROB_Clear(ROB_Clear), .ROB_NewPc(ROB_NewPc)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: program-order queue of {inst, pc}, fetch pointer, and
  // whether a live request is presented to the cache.
  logic [63:0] q[$];
  logic [31:0] m_fpc, m_icpc;
  bit          m_ics;
  // Cache model: a request is pending until answered, regardless of flushes.
  bit          c_pend;
  int unsigned c_lat;

  task automatic model_reset();
    q.delete();
    m_fpc  = '0;
    m_icpc = '0;
    m_ics  = 1'b0;
    c_pend = 1'b0;
    c_lat  = 0;
  endtask

  task automatic check_outputs();
    bit          exp_iqs;
    logic [63:0] hd;
    exp_iqs = (q.size() != 0) && !ROB_Clear;
    hd = exp_iqs ? q[0] : 64'd0;
    check("IC_S",    {31'd0, IC_S}, {31'd0, m_ics});
    check("IC_pc",   IC_pc, m_icpc);
    check("IQ_S",    {31'd0, IQ_S}, {31'd0, exp_iqs});
    check("IQ_Inst", IQ_Inst, hd[63:32]);
    check("IQ_pc",   IQ_pc, hd[31:0]);
  endtask

  task automatic model_step();
    bit pend_start, do_pop;
    int unsigned size_start;
    pend_start = c_pend;
    size_start = q.size();
    if (IC_Success) c_pend = 1'b0;
    else if (c_pend && c_lat != 0) c_lat--;
    if (ROB_Clear) begin
      q.delete();
      m_fpc = ROB_NewPc;
      m_ics = 1'b0;
    end else begin
      do_pop = (size_start != 0) && IQ_Success;
      if (do_pop) void'(q.pop_front());
      if (m_ics && IC_Success) begin
        q.push_back({IC_Inst, m_icpc});
        m_fpc = m_fpc + 32'd4;
        m_ics = 1'b0;
      end else if (!m_ics && !pend_start && size_start < DEPTH) begin
        m_ics  = 1'b1;
        m_icpc = m_fpc;
        c_pend = 1'b1;
        c_lat  = $urandom_range(0, 3);
      end
    end
  endtask

  initial begin
    int unsigned phase, pop_pct, clr_pct, stall_pct;
    model_reset();
    rst_n = 1'b0;
    #2;
    check_outputs();
    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc < 2 || cyc == 1234 || cyc == 1235 || cyc == 3101) begin
        rst_n = 1'b0;
        rdy = 1'b0; IC_Success = 1'b0; IQ_Success = 1'b0; ROB_Clear = 1'b0;
        model_reset();
        #1;
        check_outputs();
        continue;
      end
      rst_n = 1'b1;
      phase = (cyc / 500) % 4;
      case (phase)
        0:       begin pop_pct = 50; clr_pct = 2; stall_pct = 10; end
        1:       begin pop_pct = 0;  clr_pct = 0; stall_pct = 0;  end
        2:       begin pop_pct = 90; clr_pct = 3; stall_pct = 5;  end
        default: begin pop_pct = 30; clr_pct = 5; stall_pct = 25; end
      endcase
      rdy        = ($urandom_range(0, 99) >= stall_pct);
      IQ_Success = ($urandom_range(0, 99) < pop_pct);
      ROB_Clear  = ($urandom_range(0, 99) < clr_pct);
      ROB_NewPc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      IC_Success = rdy && c_pend && (c_lat == 0);
      IC_Inst    = IC_Success ? $urandom() : 32'h0;
      #1;
      check_outputs();
      if (rdy) model_step();
    end
    @(negedge clk);
    rdy = 1'b0; IC_Success = 1'b0; ROB_Clear = 1'b0; IQ_Success = 1'b0;
    #1;
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the instruction-cache fetch path and the decoder. It issues sequential fetch requests to the instruction cache, one outstanding at a time, and buffers returned instructions with their pc in a circular FIFO. It presents the oldest entry to the decoder, which pops it with a same-cycle success handshake. A ROB clear flushes the queue and redirects fetch to the corrected pc.

## Interface
- DEPTH, 16, number of queue entries; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; when low, all registers hold (reset still acts)
- IC_S  out  1  fetch request valid to the instruction cache
- IC_pc  out  32  fetch address; held stable while IC_S is high
- IC_Success  in  1  instruction returned for the outstanding request (single-cycle pulse)
- IC_Inst  in  32  returned instruction; valid with IC_Success
- IQ_S  out  1  head entry valid to the decoder
- IQ_Inst  out  32  head instruction
- IQ_pc  out  32  head pc
- IQ_Success  in  1  decoder accepted the head this cycle
- ROB_Clear  in  1  misprediction flush
- ROB_NewPc  in  32  redirect pc; valid with ROB_Clear

## Operation
- Storage: DEPTH entries of {inst[31:0], pc[31:0]}.
  - head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Fetch pc register `fpc`:
  - Next pc is always fpc+4, with 32-bit wrap; there is no prediction.
  - fpc changes only on a push (+4) or a clear (ROB_NewPc).
- Fetch FSM:
  - IDLE: IC_S=0.
    - If count<DEPTH and ROB_Clear=0: latch IC_pc<=fpc, IC_S<=1, go to WAIT.
  - WAIT: hold IC_S=1 and IC_pc.
    - On IC_Success: write {IC_Inst, IC_pc} at tail, tail++, fpc<=fpc+4, IC_S<=0, go to IDLE.
  - DRAIN: IC_S=0. Wait for the stale response.
    - On IC_Success: discard the data and go to IDLE.
- Decoder side, combinational from head:
  - IQ_S = (count!=0) && !ROB_Clear.
  - IQ_Inst and IQ_pc show the head entry when IQ_S=1, else 0.
  - Pop at the clock edge when IQ_S && IQ_Success: head++.
- Push and pop in the same cycle: count is unchanged, both pointers advance.
- Clear at the clock edge when ROB_Clear=1 (highest priority):
  - head=tail=count=0, fpc<=ROB_NewPc.
  - Any push or pop in that cycle is ignored.
  - State: WAIT becomes DRAIN with IC_S<=0. IDLE stays IDLE. DRAIN stays DRAIN.
  - If IC_Success arrives in the clear cycle itself, that response is dropped and the next state is IDLE, not DRAIN.
- Full (count==DEPTH): no new request is issued. An in-flight request cannot exist at full, because a request is only issued when count<DEPTH.
- rdy=0 freezes the FSM, pointers and fpc. The outputs keep their current values.

## Timing
- Reset values, asynchronous on rst_n=0:
  - IC_S=0, IC_pc=0, fpc=0, head=tail=count=0, state=IDLE.
  - IQ_S=0, IQ_Inst=0, IQ_pc=0.
- Reset mid-WAIT returns the FSM to IDLE. The cache is reset by the same rst_n.
- The first request is issued in the first active cycle after reset release (IC_S high after edge 1).
- Fetch-to-visible latency:
  - Data pushed at the IC_Success edge is visible on IQ_S in the next cycle.
  - With no flush, the minimum spacing between requests is 2 cycles (IDLE between two WAITs).
- The decoder handshake is fully combinational. IQ_Success may depend on IQ_S/IQ_Inst in the same cycle, and no loop exists through this block.
- After a clear from IDLE, a new request for ROB_NewPc is issued in the next cycle.
- After a clear from WAIT, the new request is issued in the cycle after the stale IC_Success.

## Test plan
- Reset release, cache returns 0x00000013 after 3 cycles -> IC_pc=0x0 requested; next cycle IQ_S=1, IQ_Inst=0x00000013, IQ_pc=0x0; following IC_pc=0x4.
- Decoder never accepts, DEPTH=16 -> exactly 16 pushes with pcs 0x0..0x3C; IC_S stays 0 afterwards. One pop then re-enables fetch at pc 0x40.
- Continuous pop and push in the same cycle with count=5 -> count stays 5 and the head/tail pointers wrap past 15 to 0 with the order preserved.
- ROB_Clear with ROB_NewPc=0x1000 while WAIT (pending pc 0x20) -> IQ_S=0 that cycle, queue empty. The stale response is discarded, then IC_pc=0x1000 and the first entry has pc 0x1000.
- ROB_Clear coincident with IC_Success and IQ_Success -> no push or pop, count=0, state IDLE, next request at ROB_NewPc.
- rdy=0 for 4 cycles during WAIT with IC_Success low -> IC_S and IC_pc held, no pointer change; operation resumes when rdy=1.
